// File: rtl/reorder_buffer_pkg.sv
// Shared widths, index types and constants for the reorder buffer slice.
// Index 0 is reserved as "not renamed", so usable slots run 1..ROB_SLOTS.
package reorder_buffer_pkg;

    localparam int ROB_IDX_W = 4;
    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam int ROB_DEPTH = 1 << ROB_IDX_W;

    typedef logic [ROB_IDX_W-1:0] rob_idx_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]    data_t;

    localparam rob_idx_t ROBNOTRENAME = '0;
    localparam rob_idx_t ROB_FIRST    = rob_idx_t'(1);
    localparam rob_idx_t ROB_SLOTS    = rob_idx_t'(ROB_DEPTH - 1);

    localparam logic  TRUE   = 1'b1;
    localparam logic  FALSE  = 1'b0;
    localparam data_t NULL32 = '0;

endpackage

// File: rtl/reorder_buffer_ptr_inc.sv
// Next ROB index with wrap from the last slot straight back to slot 1,
// so a head or tail pointer never lands on the reserved index 0.
module rob_ptr_inc
    import reorder_buffer_pkg::*;
(
    input  logic [ROB_IDX_W-1:0] i_idx,
    output logic [ROB_IDX_W-1:0] o_next
);

    assign o_next = (i_idx == ROB_SLOTS) ? ROB_FIRST : i_idx + ROB_FIRST;

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates rename tags, captures CDB
// results, retires one ready head entry per cycle and flags mispredicts.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 alloc_valid,
    input  logic                 alloc_has_rd,
    input  logic [REG_IDX_W-1:0] alloc_rd,
    input  logic                 alloc_is_branch,
    input  logic [DATA_W-1:0]    alloc_pred_pc,
    output logic [ROB_IDX_W-1:0] alloc_tag,
    output logic                 rob_full,
    input  logic                 cdb_valid,
    input  logic [ROB_IDX_W-1:0] cdb_tag,
    input  logic [DATA_W-1:0]    cdb_value,
    input  logic [DATA_W-1:0]    cdb_next_pc,
    input  logic [ROB_IDX_W-1:0] q1_tag,
    input  logic [ROB_IDX_W-1:0] q2_tag,
    output logic                 q1_ready,
    output logic                 q2_ready,
    output logic [DATA_W-1:0]    q1_value,
    output logic [DATA_W-1:0]    q2_value,
    output logic                 rob_enable,
    output logic [REG_IDX_W-1:0] rob_commit_index,
    output logic [ROB_IDX_W-1:0] rob_commit_rename,
    output logic [DATA_W-1:0]    rob_commit_value,
    output logic                 jump_wrong,
    output logic [DATA_W-1:0]    jump_target
);

    logic [ROB_DEPTH-1:0] r_valid;
    logic [ROB_DEPTH-1:0] r_ready;
    logic [ROB_DEPTH-1:0] r_has_rd;
    logic [ROB_DEPTH-1:0] r_is_br;
    reg_idx_t             r_rd      [ROB_DEPTH];
    data_t                r_pred_pc [ROB_DEPTH];
    data_t                r_value   [ROB_DEPTH];
    data_t                r_next_pc [ROB_DEPTH];

    rob_idx_t r_head;
    rob_idx_t r_tail;
    rob_idx_t r_count;

    logic     r_rob_enable;
    reg_idx_t r_commit_index;
    rob_idx_t r_commit_rename;
    data_t    r_commit_value;
    logic     r_jump_wrong;
    data_t    r_jump_target;

    rob_idx_t w_head_next;
    rob_idx_t w_tail_next;
    logic     w_alloc;
    logic     w_cdb_hit;
    logic     w_commit;
    logic     w_mispredict;

    rob_ptr_inc u_head_inc (.i_idx(r_head), .o_next(w_head_next));
    rob_ptr_inc u_tail_inc (.i_idx(r_tail), .o_next(w_tail_next));

    // Allocation handshake: alloc_valid is the request, !rob_full is the ready;
    // an entry is taken only on a cycle where both hold (and no flush is pending).
    assign alloc_tag    = r_tail;
    assign rob_full     = (r_count == ROB_SLOTS);
    assign w_alloc      = alloc_valid && !rob_full && !r_jump_wrong;
    assign w_cdb_hit    = cdb_valid && (cdb_tag != ROBNOTRENAME) && r_valid[cdb_tag];
    assign w_commit     = r_valid[r_head] && r_ready[r_head];
    assign w_mispredict = r_is_br[r_head] && (r_next_pc[r_head] != r_pred_pc[r_head]);

    assign q1_ready = (q1_tag != ROBNOTRENAME) && r_valid[q1_tag] && r_ready[q1_tag];
    assign q2_ready = (q2_tag != ROBNOTRENAME) && r_valid[q2_tag] && r_ready[q2_tag];
    assign q1_value = r_value[q1_tag];
    assign q2_value = r_value[q2_tag];

    assign rob_enable        = r_rob_enable;
    assign rob_commit_index  = r_commit_index;
    assign rob_commit_rename = r_commit_rename;
    assign rob_commit_value  = r_commit_value;
    assign jump_wrong        = r_jump_wrong;
    assign jump_target       = r_jump_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid         <= '0;
            r_ready         <= '0;
            r_head          <= ROB_FIRST;
            r_tail          <= ROB_FIRST;
            r_count         <= '0;
            r_rob_enable    <= FALSE;
            r_commit_index  <= '0;
            r_commit_rename <= ROBNOTRENAME;
            r_commit_value  <= NULL32;
            r_jump_wrong    <= FALSE;
            r_jump_target   <= NULL32;
        end else if (rdy) begin
            if (r_jump_wrong) begin
                // Flush edge: everything younger than the mispredicted branch dies.
                r_valid      <= '0;
                r_ready      <= '0;
                r_head       <= ROB_FIRST;
                r_tail       <= ROB_FIRST;
                r_count      <= '0;
                r_rob_enable <= FALSE;
                r_jump_wrong <= FALSE;
            end else begin
                r_rob_enable <= FALSE;
                r_jump_wrong <= FALSE;
                if (w_cdb_hit) begin
                    r_ready[cdb_tag] <= TRUE;
                end
                if (w_alloc) begin
                    r_valid[r_tail] <= TRUE;
                    r_ready[r_tail] <= FALSE;
                    r_tail          <= w_tail_next;
                end
                if (w_commit) begin
                    r_valid[r_head] <= FALSE;
                    r_head          <= w_head_next;
                    r_rob_enable    <= r_has_rd[r_head];
                    r_commit_index  <= r_rd[r_head];
                    r_commit_rename <= r_head;
                    r_commit_value  <= r_value[r_head];
                    if (w_mispredict) begin
                        r_jump_wrong  <= TRUE;
                        r_jump_target <= r_next_pc[r_head];
                    end
                end
                if (w_alloc && !w_commit) begin
                    r_count <= r_count + ROB_FIRST;
                end else if (!w_alloc && w_commit) begin
                    r_count <= r_count - ROB_FIRST;
                end
            end
        end
    end

    // Payload fields need no reset; they are only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (!rst && rdy && !r_jump_wrong) begin
            if (w_alloc) begin
                r_has_rd[r_tail]  <= alloc_has_rd;
                r_is_br[r_tail]   <= alloc_is_branch;
                r_rd[r_tail]      <= alloc_rd;
                r_pred_pc[r_tail] <= alloc_pred_pc;
            end
            if (w_cdb_hit) begin
                r_value[cdb_tag]   <= cdb_value;
                r_next_pc[cdb_tag] <= cdb_next_pc;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: in-order commit, wrap/full, mispredict
// flush, CDB-to-commit latency, rdy hold and operand queries.
module tb_reorder_buffer;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        alloc_valid;
    logic        alloc_has_rd;
    logic [4:0]  alloc_rd;
    logic        alloc_is_branch;
    logic [31:0] alloc_pred_pc;
    logic [3:0]  alloc_tag;
    logic        rob_full;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic [31:0] cdb_next_pc;
    logic [3:0]  q1_tag;
    logic [3:0]  q2_tag;
    logic        q1_ready;
    logic        q2_ready;
    logic [31:0] q1_value;
    logic [31:0] q2_value;
    logic        rob_enable;
    logic [4:0]  rob_commit_index;
    logic [3:0]  rob_commit_rename;
    logic [31:0] rob_commit_value;
    logic        jump_wrong;
    logic [31:0] jump_target;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected committed register writes: {rename, rd, value}.
    logic [40:0] exp_q[$];
    logic        mon_rdy;
    logic [40:0] mon_got;

    reorder_buffer dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .alloc_valid       (alloc_valid),
        .alloc_has_rd      (alloc_has_rd),
        .alloc_rd          (alloc_rd),
        .alloc_is_branch   (alloc_is_branch),
        .alloc_pred_pc     (alloc_pred_pc),
        .alloc_tag         (alloc_tag),
        .rob_full          (rob_full),
        .cdb_valid         (cdb_valid),
        .cdb_tag           (cdb_tag),
        .cdb_value         (cdb_value),
        .cdb_next_pc       (cdb_next_pc),
        .q1_tag            (q1_tag),
        .q2_tag            (q2_tag),
        .q1_ready          (q1_ready),
        .q2_ready          (q2_ready),
        .q1_value          (q1_value),
        .q2_value          (q2_value),
        .rob_enable        (rob_enable),
        .rob_commit_index  (rob_commit_index),
        .rob_commit_rename (rob_commit_rename),
        .rob_commit_value  (rob_commit_value),
        .jump_wrong        (jump_wrong),
        .jump_target       (jump_target)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] tag, input logic [4:0] rd, input logic [31:0] val);
        exp_q.push_back({tag, rd, val});
    endtask

    // Driver tasks
    task automatic do_alloc(input logic [4:0] rd, input logic has_rd, input logic is_br,
                            input logic [31:0] pred, input logic [3:0] exp_tag, input string name);
        alloc_valid     = 1'b1;
        alloc_rd        = rd;
        alloc_has_rd    = has_rd;
        alloc_is_branch = is_br;
        alloc_pred_pc   = pred;
        #1;
        check(name, alloc_tag, exp_tag);
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_cdb(input logic [3:0] tag, input logic [31:0] val, input logic [31:0] npc);
        cdb_valid   = 1'b1;
        cdb_tag     = tag;
        cdb_value   = val;
        cdb_next_pc = npc;
        tick();
        cdb_valid = 1'b0;
    endtask

    // Scoreboard: every register-file write must match the next expected commit.
    always @(posedge clk) begin
        mon_rdy = rdy && !rst;
        #1;
        if (mon_rdy && rob_enable) begin
            mon_got = {rob_commit_rename, rob_commit_index, rob_commit_value};
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL sb_unexpected: observed %0h expected no commit", mon_got);
            end else begin
                check("sb_commit", mon_got, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; rdy = 1'b1;
        alloc_valid = 1'b0; alloc_has_rd = 1'b0; alloc_rd = '0;
        alloc_is_branch = 1'b0; alloc_pred_pc = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; cdb_next_pc = '0;
        q1_tag = '0; q2_tag = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_alloc_tag", alloc_tag, 4'd1);
        check("rst_full", rob_full, 1'b0);
        check("rst_enable", rob_enable, 1'b0);
        check("rst_jump_wrong", jump_wrong, 1'b0);
        check("rst_commit_idx", rob_commit_index, 5'd0);
        check("rst_commit_ren", rob_commit_rename, 4'd0);
        check("rst_commit_val", rob_commit_value, 32'd0);
        check("rst_jump_target", jump_target, 32'd0);

        // In-order commit despite out-of-order results
        do_alloc(5'd5, 1'b1, 1'b0, 32'h0, 4'd1, "alloc_tag1");
        do_alloc(5'd6, 1'b1, 1'b0, 32'h0, 4'd2, "alloc_tag2");
        do_alloc(5'd7, 1'b1, 1'b0, 32'h0, 4'd3, "alloc_tag3");
        push_exp(4'd1, 5'd5, 32'hA);
        push_exp(4'd2, 5'd6, 32'hB);
        do_cdb(4'd2, 32'hB, 32'h0);
        check("no_commit_tag2_first", rob_enable, 1'b0);
        do_cdb(4'd1, 32'hA, 32'h0);
        check("cdb_head_edge_n1", rob_enable, 1'b0);
        tick();
        check("commit1_enable", rob_enable, 1'b1);
        check("commit1_rename", rob_commit_rename, 4'd1);
        check("commit1_index", rob_commit_index, 5'd5);
        check("commit1_value", rob_commit_value, 32'hA);
        tick();
        check("commit2_rename", rob_commit_rename, 4'd2);
        check("commit2_index", rob_commit_index, 5'd6);
        tick();
        check("commit_idle", rob_enable, 1'b0);

        // rdy low holds a ready head; query port sees captured value
        push_exp(4'd3, 5'd7, 32'h33);
        do_cdb(4'd3, 32'h33, 32'h0);
        rdy = 1'b0;
        alloc_valid = 1'b1;
        alloc_rd = 5'd20;
        alloc_has_rd = 1'b1;
        q1_tag = 4'd3;
        q2_tag = 4'd0;
        #1;
        check("q1_ready_tag3", q1_ready, 1'b1);
        check("q1_value_tag3", q1_value, 32'h33);
        check("q2_ready_tag0", q2_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_enable", rob_enable, 1'b0);
            check("hold_tail", alloc_tag, 4'd4);
        end
        alloc_valid = 1'b0;
        rdy = 1'b1;
        tick();
        check("commit3_enable", rob_enable, 1'b1);
        check("commit3_rename", rob_commit_rename, 4'd3);
        #1;
        check("q1_ready_retired", q1_ready, 1'b0);

        // Entry without rd commits silently
        do_alloc(5'd9, 1'b0, 1'b0, 32'h0, 4'd4, "alloc_tag4");
        do_cdb(4'd4, 32'h44, 32'h0);
        tick();
        check("nord_rename", rob_commit_rename, 4'd4);
        check("nord_enable", rob_enable, 1'b0);

        // Mispredicted branch flushes younger work
        do_alloc(5'd1, 1'b1, 1'b1, 32'h100, 4'd5, "alloc_branch");
        do_alloc(5'd2, 1'b1, 1'b0, 32'h0, 4'd6, "alloc_young");
        push_exp(4'd5, 5'd1, 32'h104);
        do_cdb(4'd6, 32'h66, 32'h0);
        do_cdb(4'd5, 32'h104, 32'h200);
        tick();
        check("br_jump_wrong", jump_wrong, 1'b1);
        check("br_jump_target", jump_target, 32'h200);
        check("br_link_enable", rob_enable, 1'b1);
        check("br_link_rename", rob_commit_rename, 4'd5);
        alloc_valid = 1'b1;
        alloc_rd = 5'd3;
        alloc_is_branch = 1'b0;
        tick();
        alloc_valid = 1'b0;
        q1_tag = 4'd6;
        #1;
        check("flush_pulse_end", jump_wrong, 1'b0);
        check("flush_no_commit", rob_enable, 1'b0);
        check("flush_tail", alloc_tag, 4'd1);
        check("flush_q_young", q1_ready, 1'b0);
        check("flush_full", rob_full, 1'b0);
        tick();
        check("flush_single_pulse", jump_wrong, 1'b0);
        check("flush_idle_tail", alloc_tag, 4'd1);

        // Fill all 15 slots, reject the 16th, then wrap past index 0
        for (int i = 1; i <= 15; i++) begin
            do_alloc(5'(i), 1'b1, 1'b0, 32'h0, 4'(i), "fill_tag");
        end
        check("full_set", rob_full, 1'b1);
        check("full_tail", alloc_tag, 4'd1);
        alloc_valid = 1'b1;
        alloc_rd = 5'd31;
        tick();
        alloc_valid = 1'b0;
        check("full_ignore_tail", alloc_tag, 4'd1);
        check("full_ignore_full", rob_full, 1'b1);
        push_exp(4'd1, 5'd1, 32'h1111);
        do_cdb(4'd1, 32'h1111, 32'h0);
        check("full_before_commit", rob_full, 1'b1);
        tick();
        check("full_commit_rename", rob_commit_rename, 4'd1);
        check("full_cleared", rob_full, 1'b0);
        do_alloc(5'd12, 1'b1, 1'b0, 32'h0, 4'd1, "wrap_tag1");
        check("full_again", rob_full, 1'b1);

        tick();
        tick();
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer for the Tomasulo core.
- Sits between decoder/CDB and the register file.
- Allocates one entry per decoded instruction and returns its ROB index as the rename tag. Captures results from the CDB.
- Retires one ready head entry per cycle to the register file. Detects branch mispredicts at commit and broadcasts the flush (jump_wrong).

Parameters:
- ROB_IDX_W, 4, ROB index width. Index 0 is reserved as "not renamed" (ROBNOTRENAME). Usable slots are 1..2^ROB_IDX_W-1, so 15 entries.
- REG_IDX_W, 5, architectural register index width.
- DATA_W, 32, data/PC width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; when low, all state and outputs hold
- alloc_valid  in  1  decoder requests an entry this cycle
- alloc_has_rd  in  1  instruction writes rd
- alloc_rd  in  REG_IDX_W  destination register
- alloc_is_branch  in  1  entry is a control-flow instruction
- alloc_pred_pc  in  DATA_W  predicted next PC
- alloc_tag  out  ROB_IDX_W  combinational; current tail index, i.e. the tag given to the allocating instruction
- rob_full  out  1  combinational; count == 15
- cdb_valid  in  1  result broadcast
- cdb_tag  in  ROB_IDX_W  producing entry
- cdb_value  in  DATA_W  result value
- cdb_next_pc  in  DATA_W  actual next PC (branches only)
- q1_tag, q2_tag  in  ROB_IDX_W  decoder operand lookups
- q1_ready, q2_ready  out  1  combinational; entry valid and result captured
- q1_value, q2_value  out  DATA_W  combinational; captured value
- rob_enable  out  1  registered; commit write to register file
- rob_commit_index  out  REG_IDX_W  registered; rd of the committed entry
- rob_commit_rename  out  ROB_IDX_W  registered; tag of the committed entry
- rob_commit_value  out  DATA_W  registered; committed value
- jump_wrong  out  1  registered; one-cycle flush pulse
- jump_target  out  DATA_W  registered; redirect PC, valid while jump_wrong is high

Behaviour:
- Reset:
  - head = tail = 1, count = 0, all valid/ready bits cleared.
  - rob_enable, jump_wrong = 0; rob_commit_index, rob_commit_rename, rob_commit_value, jump_target = 0.
- rdy low: nothing changes, including CDB capture. A CDB pulse arriving while rdy is low is lost; upstream guarantees it does not happen.
- Allocation:
  - Occurs when alloc_valid && !rob_full && !jump_wrong.
  - Entry[tail] is written with valid=1, ready=0 and the alloc fields.
  - tail advances 1→2→…→15→1 and never takes value 0.
  - alloc_valid while full is ignored; the decoder must stall.
- CDB capture: when cdb_valid and entry[cdb_tag] is valid, set ready=1 and store value and next_pc. A CDB write to an invalid tag or to tag 0 is ignored.
- Commit:
  - Occurs when entry[head] is valid and ready at the clock edge. Ready is sampled registered, so a CDB write to the head commits one cycle later at the earliest.
  - Next cycle outputs: rob_enable = has_rd; rob_commit_index = rd; rob_commit_rename = head; rob_commit_value = value.
  - The entry is invalidated, head advances with the same wrap rule, and count decrements.
  - rob_enable is high for exactly one cycle per committed entry with rd.
- Simultaneous alloc and commit: count is unchanged. Allocation is allowed when count == 15 only if commit frees a slot in that same cycle? No. rob_full is combinational on the current count, so there is no same-cycle reuse.
- Mispredict:
  - On commit of a branch whose next_pc != pred_pc, drive jump_wrong = 1 and jump_target = next_pc for one cycle. The branch's own rd commit still occurs (JAL/JALR link).
  - On the edge where jump_wrong is high, clear all valid bits and set head = tail = 1, count = 0.
  - Allocation and CDB captures in the jump_wrong cycle are dropped. The register file clears its renames on the same pulse.
- Commit outputs are never asserted in the cycle after the flush edge.
- Query port:
  - q*_ready = 0 for tag 0 and for invalid entries.
  - The query port does not forward the same-cycle CDB value; the decoder snoops the CDB itself.
- Reset has priority over everything, including mid-flush and mid-commit.

Decomposition:
- Shared definitions: ROBINDEX/REGINDEX/DATALEN ranges, ROBNOTRENAME = 0, ROB_SLOTS = 15, TRUE/FALSE, NULL32.
- One natural sub-module: rob_ptr_inc (combinational next-index with 15→1 wrap), reused for head and tail.

Test Plan:
- Reset, then alloc 3 entries (rd = 5, 6, 7). Required: alloc_tag values 1, 2, 3. CDB writes tag 2, then tag 1 (value 0xA). Required: commits are in order, tag 1 then tag 2; rob_commit_index = 5 and rob_commit_value = 0xA on the first commit.
- Fill 15 entries with no commits. Required: rob_full = 1 and a 16th alloc is ignored. Then commit one entry. Required: rob_full = 0; the next alloc receives tag 1, confirming wrap skips 0.
- Branch at head with pred_pc = 0x100 and CDB next_pc = 0x200. Required: jump_wrong is a single pulse with jump_target = 0x200; next cycle count = 0 and alloc_tag = 1; an alloc presented during the pulse is dropped.
- CDB writes the head in cycle N. Required: rob_enable rises at edge N+2, not N+1. Entry with alloc_has_rd = 0 commits with rob_enable = 0.
- Hold rdy = 0 for 5 cycles with a ready head. Required: no commit and no pointer movement. Query tag 3 after its CDB write: q1_ready = 1 with the correct value; query tag 0: q1_ready = 0.
